pattern_counter: RTL and testbench
==================================

# pattern_counter

Hardware accelerator for bit-pattern search over a byte string held in data memory; it is the parametrised successor of the program-3 software search. On a `req` pulse it streams `len` bytes from the data memory starting at `base_addr` and computes three counts: pattern hits contained in a byte, bytes with at least one hit, and hits anywhere in the bit string (byte crossing allowed). It then writes the three counts back to memory at `base_addr+len`, `+1` and `+2`, and raises `done`. It sits beside the core on the data-memory port, under the same `req`/`done` handshake as `top_level`.

## Interface
- `PAT_W`, 5, pattern width in bits; legal range 1..8.
- `ADDR_W`, 8, data-memory address width; also the width of `len`.
- `CNT_W`, 8, width of each result counter; counters saturate at 2^CNT_W−1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: start request; sampled only in IDLE.
- `pat` in PAT_W: pattern; sampled with `req`.
- `base_addr` in ADDR_W: first byte address; sampled with `req`.
- `len` in ADDR_W: byte count, 0..2^ADDR_W−1; sampled with `req`.
- `mem_raddr` out ADDR_W: read address; synchronous read, 1-cycle latency.
- `mem_rdata` in 8: read data for the address presented in the previous cycle.
- `mem_we` out 1: write enable.
- `mem_waddr` out ADDR_W: write address.
- `mem_wdata` out 8: write data; low 8 bits of the counter being written.
- `busy` out 1: high from the cycle after `req` is accepted until `done` rises.
- `done` out 1: result valid; held high until the next accepted `req`.
- `ctb`, `cto`, `cts` out CNT_W each: in-byte hits, bytes with ≥1 hit, and string hits.

## Operation
- Bit order:
  - The string is byte `base_addr` first, MSB first.
  - In-byte windows are `byte[k+PAT_W-1:k]` for k = 0..8−PAT_W.
  - String windows are every PAT_W consecutive string bits, giving `len*8−PAT_W+1` windows (0 if negative).
- States:
  - IDLE: on `req`, latch inputs, clear counters, clear `done`. Go to RUN if `len`≠0, else WR0.
  - RUN: each cycle issue the next address and accumulate the byte returned for the previous address.
    - Keep the last 7 bits of the previous byte in a 15-bit window.
    - String hits for the current byte count windows ending inside it whose start index is ≥0, tracked by a bits-seen count.
    - After the last byte is accumulated, go to WR0.
  - WR0, WR1, WR2: write `ctb`, `cto`, `cts` to `base_addr+len`, `+1`, `+2`, one write per cycle. Then go to IDLE with `done`=1.
- Arithmetic:
  - Per-byte increments are added with saturation at 2^CNT_W−1; the counter never wraps.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Boundaries:
  - `req` while busy is ignored.
  - `req` in the same cycle `done` would rise is not sampled; it must be reasserted in IDLE.
  - `len`=0 writes three zero bytes.
  - `PAT_W`=8 gives one in-byte window per byte.
- Reset (any time, including mid-run):
  - All outputs go to 0: `busy`, `done`, `mem_we`, `mem_raddr`, `mem_waddr`, `mem_wdata`, `ctb`, `cto`, `cts`.
  - The FSM returns to IDLE; no partial write completes.

## Timing
- Edge 0 samples `req`.
- `mem_raddr` = `base_addr+k` in the cycle after edge k, for k = 0..len−1.
- Byte k is accumulated at edge k+2.
- Writes are committed at edges len+2, len+3, len+4.
- `done` is high after edge len+4 (len=32: 36 cycles). For `len`=0, writes commit at edges 1..3 and `done` rises at edge 3.
- `mem_we` is high only in WR0–WR2.
- `ctb`/`cto`/`cts` outputs are stable while `done`=1.

## Test plan
- PAT_W=5, pat=00000, 32×0x00, base 0 → ctb=128, cto=32, cts=252; mem[32..34] = 128, 32, 252; `done` at edge 36.
- pat=10101, 32×0x55 → ctb=64, cto=32, cts=126.
- pat=11111, len=2, bytes 0x07, 0xC0 → ctb=0, cto=0, cts=1 (cross-byte hit only).
- PAT_W=1, pat=0, 32×0x00, CNT_W=8 → ctb=255 (saturated), cto=32, cts=255 (saturated).
- len=0, base 10 → mem[10..12]=0, `done` at edge 3; `req` pulsed during RUN of a 32-byte job → ignored, results unchanged.
- Random pat/bytes vs. the software model over 20 jobs, plus `rst_n` low at edge 10 of a run → all outputs 0, no `mem_we`; the next job is correct.

Source files
------------

// File: rtl/pattern_counter_if.sv
// Request/result handshake and data-memory port of the pattern counter.
// The accelerator connects through the slave modport. The core, together with
// the memory, connects through the master modport.
interface pattern_counter_if #(
    parameter int PAT_W  = 5,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              req;
    logic [PAT_W-1:0]  pat;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  ctb;
    logic [CNT_W-1:0]  cto;
    logic [CNT_W-1:0]  cts;

    modport master (
        output req, pat, base_addr, len, mem_rdata,
        input  mem_raddr, mem_we, mem_waddr, mem_wdata, busy, done, ctb, cto, cts
    );

    modport slave (
        input  req, pat, base_addr, len, mem_rdata,
        output mem_raddr, mem_we, mem_waddr, mem_wdata, busy, done, ctb, cto, cts
    );
endinterface

// File: rtl/pattern_counter.sv
// Bit-pattern search accelerator. It streams len bytes from data memory and
// counts three things: pattern hits inside single bytes, bytes that contain at
// least one hit, and hits anywhere in the MSB-first bit string. It then writes
// the three counts back to memory directly after the string.
module pattern_counter #(
    parameter int PAT_W  = 5,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pattern_counter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WR0,
        S_WR1,
        S_WR2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q;
    logic [PAT_W-1:0]  pat_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] issue_left_q;   // reads still to issue after the current one
    logic              rd_pend_q;      // mem_raddr this cycle is a real read
    logic              rd_valid_q;     // mem_rdata this cycle belongs to the job
    logic [6:0]        win_q;          // last 7 string bits of the previous byte
    logic [3:0]        seen_q;         // string bits already consumed, saturating at 8
    logic [CNT_W-1:0]  ctb_q, cto_q, cts_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;
    logic              busy_q;
    logic              done_q;

    logic [14:0]       window_d;
    logic [3:0]        ctb_inc_d;
    logic [3:0]        cts_inc_d;
    logic [CNT_W-1:0]  ctb_d, cto_d, cts_d;

    // Add a per-byte increment, clamping at the counter maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       inc);
        logic [CNT_W+3:0] s;
        s = (CNT_W+4)'(a) + (CNT_W+4)'(inc);
        return (s > (CNT_W+4)'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
    endfunction

    // Count the windows in the byte now on mem_rdata, then form the saturated next counts.
    always_comb begin
        // NOTE: every output of this block gets a value before any conditional
        // update, so no path can leave it unassigned and infer a latch.
        window_d  = {win_q, bus.mem_rdata};
        ctb_inc_d = '0;
        cts_inc_d = '0;
        for (int e = 0; e < 8; e++) begin
            if (window_d[e +: PAT_W] == pat_q) begin
                // A window lying wholly inside the current byte is an in-byte hit.
                if (e <= 8 - PAT_W)
                    ctb_inc_d = ctb_inc_d + 4'd1;
                // A string window counts only if its first bit has already been streamed.
                if (e + PAT_W <= 8 + int'(seen_q))
                    cts_inc_d = cts_inc_d + 4'd1;
            end
        end
        ctb_d = sat_add(ctb_q, ctb_inc_d);
        cto_d = sat_add(cto_q, {3'd0, (ctb_inc_d != 4'd0)});
        cts_d = sat_add(cts_q, cts_inc_d);
    end

    // Control FSM: accept the job, stream the reads, accumulate, write back the three results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pat_q        <= '0;
            base_q       <= '0;
            len_q        <= '0;
            raddr_q      <= '0;
            issue_left_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            win_q        <= '0;
            seen_q       <= '0;
            ctb_q        <= '0;
            cto_q        <= '0;
            cts_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // right-hand side below reads the value from before this edge.
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        pat_q      <= bus.pat;
                        base_q     <= bus.base_addr;
                        len_q      <= bus.len;
                        ctb_q      <= '0;
                        cto_q      <= '0;
                        cts_q      <= '0;
                        win_q      <= '0;
                        seen_q     <= '0;
                        rd_valid_q <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.len != '0) begin
                            state_q      <= S_RUN;
                            raddr_q      <= bus.base_addr;
                            issue_left_q <= bus.len - ADDR_W'(1);
                            rd_pend_q    <= 1'b1;
                        end else begin
                            state_q <= S_WR0;
                            we_q    <= 1'b1;
                            waddr_q <= bus.base_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                S_RUN: begin
                    rd_valid_q <= rd_pend_q;
                    if (rd_pend_q) begin
                        if (issue_left_q != '0) begin
                            raddr_q      <= raddr_q + ADDR_W'(1);
                            issue_left_q <= issue_left_q - ADDR_W'(1);
                        end else begin
                            rd_pend_q <= 1'b0;
                        end
                    end
                    if (rd_valid_q) begin
                        ctb_q  <= ctb_d;
                        cto_q  <= cto_d;
                        cts_q  <= cts_d;
                        win_q  <= bus.mem_rdata[6:0];
                        seen_q <= (seen_q >= 4'd8) ? 4'd8 : seen_q + 4'd8;
                        // No read in flight after this one: this was the last byte.
                        if (!rd_pend_q) begin
                            state_q <= S_WR0;
                            we_q    <= 1'b1;
                            waddr_q <= base_q + len_q;
                            wdata_q <= 8'(ctb_d);
                        end
                    end
                end
                S_WR0: begin
                    state_q <= S_WR1;
                    waddr_q <= waddr_q + ADDR_W'(1);
                    wdata_q <= 8'(cto_q);
                end
                S_WR1: begin
                    state_q <= S_WR2;
                    waddr_q <= waddr_q + ADDR_W'(1);
                    wdata_q <= 8'(cts_q);
                end
                S_WR2: begin
                    state_q <= S_IDLE;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_raddr = raddr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ctb       = ctb_q;
    assign bus.cto       = cto_q;
    assign bus.cts       = cts_q;

endmodule

// File: tb/tb_pattern_counter.sv
// Self-checking bench for pattern_counter. It uses two instances (PAT_W=5 and
// PAT_W=1), each backed by its own synchronous memory, and compares them
// against a bit-string reference model.
module tb_pattern_counter;

    localparam int AW = 8;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_counter_if #(.PAT_W(5), .ADDR_W(AW), .CNT_W(CW)) bus5 ();
    pattern_counter_if #(.PAT_W(1), .ADDR_W(AW), .CNT_W(CW)) bus1 ();

    pattern_counter #(.PAT_W(5), .ADDR_W(AW), .CNT_W(CW)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5)
    );
    pattern_counter #(.PAT_W(1), .ADDR_W(AW), .CNT_W(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       ld_we   = 1'b0;
    int         ld_sel  = 0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    int         we_cnt0 = 0;
    int         we_cnt1 = 0;

    // Synchronous-read memories with a bench-side load port and write counters.
    always @(posedge clk) begin
        bus5.mem_rdata <= mem0[bus5.mem_raddr];
        bus1.mem_rdata <= mem1[bus1.mem_raddr];
        if (bus5.mem_we) mem0[bus5.mem_waddr] <= bus5.mem_wdata;
        if (bus1.mem_we) mem1[bus1.mem_waddr] <= bus1.mem_wdata;
        we_cnt0 <= we_cnt0 + int'(bus5.mem_we);
        we_cnt1 <= we_cnt1 + int'(bus1.mem_we);
        if (ld_we) begin
            if (ld_sel == 0) mem0[ld_addr] <= ld_data;
            else             mem1[ld_addr] <= ld_data;
        end
    end

    int checks   = 0;
    int failures = 0;
    int job_bytes [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int w, input logic r, input int pat, input int base, input int len);
        if (w == 0) begin
            bus5.req = r; bus5.pat = 5'(pat); bus5.base_addr = 8'(base); bus5.len = 8'(len);
        end else begin
            bus1.req = r; bus1.pat = 1'(pat); bus1.base_addr = 8'(base); bus1.len = 8'(len);
        end
    endtask

    task automatic get_out(input int w, output logic [7:0] ctb, output logic [7:0] cto,
                           output logic [7:0] cts, output logic busy, output logic done);
        if (w == 0) begin
            ctb = bus5.ctb; cto = bus5.cto; cts = bus5.cts; busy = bus5.busy; done = bus5.done;
        end else begin
            ctb = bus1.ctb; cto = bus1.cto; cts = bus1.cts; busy = bus1.busy; done = bus1.done;
        end
    endtask

    task automatic poke(input int w, input int addr, input int data);
        @(negedge clk);
        ld_we = 1'b1; ld_sel = w; ld_addr = 8'(addr); ld_data = 8'(data);
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    function automatic int peek(input int w, input int addr);
        return (w == 0) ? int'(mem0[8'(addr)]) : int'(mem1[8'(addr)]);
    endfunction

    // Reference: flatten the bytes into an MSB-first bit list and count windows directly.
    function automatic void model(input int pw, input int pat, input int len,
                                  output int ctb, output int cto, output int cts);
        int bitv[$];
        int hits, v;
        ctb = 0; cto = 0; cts = 0;
        for (int i = 0; i < len; i++) begin
            hits = 0;
            for (int k = 0; k <= 8 - pw; k++)
                if (((job_bytes[i] >> k) & ((1 << pw) - 1)) == pat) hits++;
            ctb += hits;
            if (hits > 0) cto++;
            for (int j = 7; j >= 0; j--) bitv.push_back((job_bytes[i] >> j) & 1);
        end
        for (int s = 0; s + pw <= bitv.size(); s++) begin
            v = 0;
            for (int j = 0; j < pw; j++) v = v * 2 + bitv[s + j];
            if (v == pat) cts++;
        end
        if (ctb > 255) ctb = 255;
        if (cto > 255) cto = 255;
        if (cts > 255) cts = 255;
    endfunction

    task automatic run_job(input int w, input int pat, input int base, input int len,
                           input bit glitch, input string tag);
        int pw, e_ctb, e_cto, e_cts, n, we_before, exp_n;
        logic [7:0] ctb, cto, cts;
        logic busy, done;
        pw = (w == 0) ? 5 : 1;
        for (int i = 0; i < len; i++) poke(w, base + i, job_bytes[i]);
        for (int i = 0; i < 3; i++) poke(w, base + len + i, 'hEE);
        model(pw, pat, len, e_ctb, e_cto, e_cts);
        @(negedge clk);
        we_before = (w == 0) ? we_cnt0 : we_cnt1;
        set_req(w, 1'b1, pat, base, len);
        @(posedge clk);                      // edge 0
        @(negedge clk);
        set_req(w, 1'b0, pat, base, len);
        n = 0;
        get_out(w, ctb, cto, cts, busy, done);
        check({tag, "_busy_after_req"}, busy, 1);
        check({tag, "_done_cleared"}, done, 0);
        while (n < 600) begin
            get_out(w, ctb, cto, cts, busy, done);
            if (done) break;
            if (glitch && n == 5) set_req(w, 1'b1, pat ^ 1, base + 7, 3);
            else                  set_req(w, 1'b0, pat, base, len);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        set_req(w, 1'b0, pat, base, len);
        exp_n = (len == 0) ? 3 : len + 4;
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_done_edge"}, n, exp_n);
        check({tag, "_ctb"}, ctb, e_ctb);
        check({tag, "_cto"}, cto, e_cto);
        check({tag, "_cts"}, cts, e_cts);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_mem_ctb"}, peek(w, base + len), e_ctb);
        check({tag, "_mem_cto"}, peek(w, base + len + 1), e_cto);
        check({tag, "_mem_cts"}, peek(w, base + len + 2), e_cts);
        check({tag, "_write_count"}, ((w == 0) ? we_cnt0 : we_cnt1) - we_before, 3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ctb, cto, cts;
        logic busy, done;
        int pat, base, len, w, we_before;

        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            get_out(i, ctb, cto, cts, busy, done);
            check("reset_ctb", ctb, 0);
            check("reset_cto", cto, 0);
            check("reset_cts", cts, 0);
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
        end
        check("reset_we", bus5.mem_we, 0);
        check("reset_raddr", bus5.mem_raddr, 0);
        rst_n = 1'b1;

        // All-zero string, pattern 00000.
        for (int i = 0; i < 32; i++) job_bytes[i] = 'h00;
        run_job(0, 0, 0, 32, 1'b0, "zeros");
        get_out(0, ctb, cto, cts, busy, done);
        check("zeros_ctb_const", ctb, 128);
        check("zeros_cto_const", cto, 32);
        check("zeros_cts_const", cts, 252);
        repeat (5) @(negedge clk);
        get_out(0, ctb, cto, cts, busy, done);
        check("hold_done", done, 1);
        check("hold_cts", cts, 252);

        // Alternating bits, pattern 10101.
        for (int i = 0; i < 32; i++) job_bytes[i] = 'h55;
        run_job(0, 'b10101, 40, 32, 1'b0, "alt");
        get_out(0, ctb, cto, cts, busy, done);
        check("alt_ctb_const", ctb, 64);
        check("alt_cto_const", cto, 32);
        check("alt_cts_const", cts, 126);

        // A hit that exists only across the byte boundary.
        job_bytes[0] = 'h07;
        job_bytes[1] = 'hC0;
        run_job(0, 'b11111, 100, 2, 1'b0, "cross");
        get_out(0, ctb, cto, cts, busy, done);
        check("cross_ctb_const", ctb, 0);
        check("cross_cto_const", cto, 0);
        check("cross_cts_const", cts, 1);

        // PAT_W=1: both counters saturate.
        for (int i = 0; i < 32; i++) job_bytes[i] = 'h00;
        run_job(1, 0, 0, 32, 1'b0, "sat");
        get_out(1, ctb, cto, cts, busy, done);
        check("sat_ctb_const", ctb, 255);
        check("sat_cto_const", cto, 32);
        check("sat_cts_const", cts, 255);

        // Zero-length job writes three zeros.
        run_job(0, 3, 10, 0, 1'b0, "len0");
        check("len0_mem10", peek(0, 10), 0);

        // A second req during RUN must be ignored.
        for (int i = 0; i < 32; i++) job_bytes[i] = int'($urandom_range(0, 255));
        run_job(0, int'($urandom_range(0, 31)), 60, 32, 1'b1, "glitch");

        // Random jobs on both instances.
        for (int j = 0; j < 20; j++) begin
            w    = (j % 4 == 3) ? 1 : 0;
            pat  = (w == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 1));
            len  = int'($urandom_range(0, 40));
            base = int'($urandom_range(0, 255));
            for (int i = 0; i < len; i++) job_bytes[i] = int'($urandom_range(0, 255));
            run_job(w, pat, base, len, 1'b0, $sformatf("rnd%0d", j));
        end

        // Reset asserted at edge 10 of a 32-byte run.
        len  = 32;
        base = 128;
        for (int i = 0; i < len; i++) job_bytes[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < len; i++) poke(0, base + i, job_bytes[i]);
        for (int i = 0; i < 3; i++) poke(0, base + len + i, 'hEE);
        @(negedge clk);
        we_before = we_cnt0;
        set_req(0, 1'b1, 7, base, len);
        @(posedge clk);
        #1 set_req(0, 1'b0, 7, base, len);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        get_out(0, ctb, cto, cts, busy, done);
        check("rst_ctb", ctb, 0);
        check("rst_cto", cto, 0);
        check("rst_cts", cts, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", bus5.mem_we, 0);
        check("rst_raddr", bus5.mem_raddr, 0);
        check("rst_waddr", bus5.mem_waddr, 0);
        check("rst_wdata", bus5.mem_wdata, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_no_writes", we_cnt0 - we_before, 0);
        check("rst_mem_untouched", peek(0, base + len), 'hEE);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) job_bytes[i] = int'($urandom_range(0, 255));
        run_job(0, int'($urandom_range(0, 31)), 200, 24, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
